// File: rtl/pkt_frame_ctrl_if.sv
// Packet stream bus: upstream beat channel (in_*) and downstream beat channel (out_*).
// The framing controller takes the slave view; the traffic source/sink takes the master view.
interface pkt_frame_ctrl_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic          in_sop;
  logic          in_eop;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sop;
  logic          out_eop;
  logic          out_abort;
  logic [DW-1:0] out_data;

  modport slave (
    input  in_valid, in_sop, in_eop, in_data, out_ready,
    output in_ready, out_valid, out_sop, out_eop, out_abort, out_data
  );

  modport master (
    output in_valid, in_sop, in_eop, in_data, out_ready,
    input  in_ready, out_valid, out_sop, out_eop, out_abort, out_data
  );
endinterface

// File: rtl/pkt_frame_ctrl.sv
// Packet framing controller: checks SOP/EOP ordering and packet length, forwards legal
// beats through one output register with backpressure, closes broken packets with an
// aborted EOP beat, drops stray beats, and counts framing violations.
module pkt_frame_ctrl #(
  parameter int DW      = 8,
  parameter int MIN_LEN = 2,
  parameter int MAX_LEN = 16,
  parameter int ECW     = 8
) (
  input  logic           clk,
  input  logic           rst,
  pkt_frame_ctrl_if.slave bus,
  output logic           packet_error,
  output logic [ECW-1:0] err_count,
  input  logic           err_clr
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_MIN = LW'(MIN_LEN);
  localparam logic [LW-1:0] LEN_SAT = LW'(MAX_LEN + 1);
  // A lone sop&eop beat is a short packet whenever packets need more than one beat.
  localparam bit SINGLE_ILLEGAL = (MIN_LEN > 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [LW-1:0] len_reg, len_next;
  logic [LW-1:0] len_inc;

  logic          accept;
  logic          fwd, fwd_sop, fwd_eop, fwd_abort, err;

  logic          out_valid_reg;
  logic          out_sop_reg, out_eop_reg, out_abort_reg;
  logic [DW-1:0] out_data_reg;
  logic          packet_error_reg;
  logic [ECW-1:0] err_count_reg;

  // A beat moves whenever the output register is empty or being drained this cycle.
  assign bus.in_ready  = !out_valid_reg | bus.out_ready;
  assign accept        = bus.in_valid & bus.in_ready;

  // Beat count including the current beat; saturates so it can never wrap.
  assign len_inc = (len_reg == LEN_SAT) ? len_reg : len_reg + 1'b1;

  // State and beat counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
    end
  end

  // Framing decision for the accepted beat: forward/drop, flags, error, next state.
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    fwd        = 1'b0;
    fwd_sop    = 1'b0;
    fwd_eop    = 1'b0;
    fwd_abort  = 1'b0;
    err        = 1'b0;
    if (accept) begin
      case (state_reg)
        IDLE: begin
          if (bus.in_sop) begin
            fwd     = 1'b1;
            fwd_sop = 1'b1;
            if (bus.in_eop) begin
              fwd_eop = 1'b1;
              if (SINGLE_ILLEGAL) begin
                err       = 1'b1;
                fwd_abort = 1'b1;
              end
            end else begin
              len_next   = LW'(1);
              state_next = BODY;
            end
          end else begin
            // Beat outside any packet: discard it and everything up to its eop.
            err = 1'b1;
            if (!bus.in_eop) state_next = DROP;
          end
        end
        BODY: begin
          fwd = 1'b1;
          if (bus.in_sop || (len_inc > LEN_MAX)) begin
            // New sop or overlong packet: close the current packet as aborted.
            err        = 1'b1;
            fwd_eop    = 1'b1;
            fwd_abort  = 1'b1;
            len_next   = '0;
            state_next = bus.in_eop ? IDLE : DROP;
          end else if (bus.in_eop) begin
            fwd_eop    = 1'b1;
            len_next   = '0;
            state_next = IDLE;
            if (len_inc < LEN_MIN) begin
              err       = 1'b1;
              fwd_abort = 1'b1;
            end
          end else begin
            len_next = len_inc;
          end
        end
        DROP: begin
          if (bus.in_eop) state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
          len_next   = '0;
        end
      endcase
    end
  end

  // Output stage: load on a forwarded beat, clear valid once drained, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_sop_reg   <= 1'b0;
      out_eop_reg   <= 1'b0;
      out_abort_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (fwd) begin
      out_valid_reg <= 1'b1;
      out_sop_reg   <= fwd_sop;
      out_eop_reg   <= fwd_eop;
      out_abort_reg <= fwd_abort;
      out_data_reg  <= bus.in_data;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Error pulse and saturating error counter; clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      packet_error_reg <= 1'b0;
      err_count_reg    <= '0;
    end else begin
      packet_error_reg <= err;
      if (err_clr)
        err_count_reg <= '0;
      else if (err && (err_count_reg != {ECW{1'b1}}))
        err_count_reg <= err_count_reg + 1'b1;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_sop   = out_sop_reg;
  assign bus.out_eop   = out_eop_reg;
  assign bus.out_abort = out_abort_reg;
  assign bus.out_data  = out_data_reg;
  assign packet_error  = packet_error_reg;
  assign err_count     = err_count_reg;

endmodule

// File: tb/tb_pkt_frame_ctrl.sv
// Testbench for pkt_frame_ctrl: directed framing scenarios plus randomized traffic,
// compared cycle by cycle against a packet-level reference model.
module tb_pkt_frame_ctrl;

  localparam int DW      = 8;
  localparam int MIN_LEN = 2;
  localparam int MAX_LEN = 16;
  localparam int ECW     = 8;
  localparam int CNT_MAX = (1 << ECW) - 1;

  logic           clk;
  logic           rst;
  logic           packet_error;
  logic [ECW-1:0] err_count;
  logic           err_clr;

  pkt_frame_ctrl_if #(.DW(DW)) bus ();

  pkt_frame_ctrl #(
    .DW(DW), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .ECW(ECW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .packet_error(packet_error),
    .err_count(err_count),
    .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: packet-level view of the stream.
  bit          in_packet;
  bit          discarding;
  int          beats;
  bit          exp_ov;
  bit          exp_sop, exp_eop, exp_abort;
  logic [7:0]  exp_data;
  bit          exp_err;
  int          exp_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    in_packet  = 0;
    discarding = 0;
    beats      = 0;
    exp_ov     = 0;
    exp_sop    = 0;
    exp_eop    = 0;
    exp_abort  = 0;
    exp_data   = '0;
    exp_err    = 0;
    exp_cnt    = 0;
  endtask

  // Classify one accepted beat from the framing rules.
  task automatic model_beat(input bit s, input bit e,
                            output bit fwd, output bit osop, output bit oeop,
                            output bit oab, output bit err);
    int n;
    fwd = 0; osop = 0; oeop = 0; oab = 0; err = 0;
    if (discarding) begin
      if (e) discarding = 0;
    end else if (!in_packet) begin
      if (!s) begin
        err = 1;
        discarding = !e;
      end else if (e) begin
        fwd = 1; osop = 1; oeop = 1;
        oab = (MIN_LEN > 1);
        err = (MIN_LEN > 1);
      end else begin
        fwd = 1; osop = 1;
        in_packet = 1;
        beats = 1;
      end
    end else begin
      n = beats + 1;
      fwd = 1;
      if (s || n > MAX_LEN) begin
        err = 1; oeop = 1; oab = 1;
        in_packet = 0;
        discarding = !e;
      end else if (e) begin
        oeop = 1;
        in_packet = 0;
        if (n < MIN_LEN) begin
          err = 1; oab = 1;
        end
      end else begin
        beats = n;
      end
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance the model.
  task automatic step(input bit v, input bit s, input bit e, input logic [7:0] d,
                      input bit ordy, input bit clr, output bit acc);
    bit fwd, osop, oeop, oab, err;
    bus.in_valid  = v;
    bus.in_sop    = s;
    bus.in_eop    = e;
    bus.in_data   = d;
    bus.out_ready = ordy;
    err_clr       = clr;
    @(negedge clk);
    check("out_valid", bus.out_valid, exp_ov);
    check("in_ready", bus.in_ready, !exp_ov || ordy);
    check("packet_error", packet_error, exp_err);
    check("err_count", err_count, exp_cnt);
    if (exp_ov) begin
      check("out_sop", bus.out_sop, exp_sop);
      check("out_eop", bus.out_eop, exp_eop);
      check("out_abort", bus.out_abort, exp_abort);
      check("out_data", bus.out_data, exp_data);
    end
    acc = v && (!exp_ov || ordy);
    fwd = 0; err = 0; osop = 0; oeop = 0; oab = 0;
    if (acc) model_beat(s, e, fwd, osop, oeop, oab, err);
    if (fwd) begin
      exp_ov = 1; exp_sop = osop; exp_eop = oeop; exp_abort = oab; exp_data = d;
    end else if (ordy) begin
      exp_ov = 0;
    end
    exp_err = err;
    if (clr) exp_cnt = 0;
    else if (err && exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 0; bus.in_sop = 0; bus.in_eop = 0; bus.in_data = '0;
    bus.out_ready = 1; err_clr = 0;
    model_reset();
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sop", bus.out_sop, 0);
    check("rst_out_eop", bus.out_eop, 0);
    check("rst_out_abort", bus.out_abort, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_packet_error", packet_error, 0);
    check("rst_err_count", err_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Send one beat and keep retrying while backpressured (bounded).
  task automatic send(input bit s, input bit e, input bit ordy);
    bit acc;
    int tries;
    acc = 0;
    tries = 0;
    while (!acc && tries < 50) begin
      step(1, s, e, 8'($urandom), ordy, 0, acc);
      tries++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 1, 0, acc);
  endtask

  bit acc_g;
  int gen_pos, gen_len;
  bit gs, ge;

  initial begin
    rst = 1'b1;
    err_clr = 0;
    do_reset();

    // T1: legal 4-beat packet
    send(1, 0, 1); send(0, 0, 1); send(0, 0, 1); send(0, 1, 1);
    idle(2);
    // T2: single-beat packet is too short
    send(1, 1, 1);
    idle(2);
    // T3: overlong packet, aborted on the 17th beat, rest dropped until eop
    send(1, 0, 1);
    for (int i = 0; i < 18; i++) send(0, 0, 1);
    send(0, 1, 1);
    idle(2);
    // T4: sop inside a packet closes it as aborted, then drop to eop
    send(1, 0, 1); send(0, 0, 1); send(0, 0, 1);
    send(1, 0, 1); send(0, 0, 1); send(0, 1, 1);
    send(1, 0, 1); send(0, 1, 1);
    idle(2);
    // T5: downstream stall mid-packet
    send(1, 0, 1); send(0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'($urandom), 0, 0, acc_g);
    send(0, 0, 1); send(0, 1, 1);
    idle(2);
    // T6: reset mid-packet, then a clean packet, then clear racing an error
    send(1, 0, 1); send(0, 0, 1);
    do_reset();
    send(1, 0, 1); send(0, 0, 1); send(0, 1, 1);
    send(0, 1, 1);                       // stray beat: error
    step(1, 0, 1, 8'h5a, 1, 1, acc_g);   // another error with clear in the same cycle
    idle(2);

    // Saturation: a long run of stray beats
    for (int i = 0; i < CNT_MAX + 15; i++)
      step(1, 0, 1, 8'($urandom), ($urandom % 4) != 0, 0, acc_g);
    idle(2);
    step(0, 0, 0, 8'h00, 1, 1, acc_g);
    idle(1);

    // Randomized packet traffic with occasional framing faults
    gen_pos = 0;
    gen_len = $urandom_range(1, MAX_LEN + 3);
    for (int i = 0; i < 3000; i++) begin
      gs = (gen_pos == 0) ? (($urandom % 16) != 0) : (($urandom % 40) == 0);
      ge = (gen_pos >= gen_len - 1) ? (($urandom % 24) != 0) : 1'b0;
      step(($urandom % 4) != 0, gs, ge, 8'($urandom), ($urandom % 4) != 0,
           ($urandom % 128) == 0, acc_g);
      if (acc_g) begin
        if (ge) begin
          gen_pos = 0;
          gen_len = $urandom_range(1, MAX_LEN + 3);
        end else begin
          gen_pos++;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
